// File: rtl/core_pkg.sv
// Shared types for the store buffer: store size codes, drain FSM states
// and the record kept for each buffered store.
package core_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_RSVD = 2'd3
  } st_size_e;

  typedef enum logic {
    IDLE  = 1'b0,
    WRITE = 1'b1
  } sb_state_e;

  // One buffered store: word address, lane-positioned data, byte enables.
  typedef struct packed {
    logic [29:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } sb_entry_t;

  // Unshifted byte-enable pattern for a store size; reserved size gets none.
  function automatic logic [3:0] size_to_mask(input st_size_e size);
    case (size)
      SIZE_BYTE: size_to_mask = 4'b0001;
      SIZE_HALF: size_to_mask = 4'b0011;
      SIZE_WORD: size_to_mask = 4'b1111;
      default:   size_to_mask = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/sb_lane_encode.sv
// Turns a right-aligned store (size + low address bits) into byte-lane
// enables and lane-positioned data, and flags stores that cannot be encoded.
module sb_lane_encode
  import core_pkg::*;
(
  input  logic [1:0]  offset,
  input  logic [1:0]  size,
  input  logic [31:0] data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned
);

  // Misalignment check and lane shifting; bad stores are never enqueued,
  // so their be/wdata values are don't-care.
  always_comb begin
    misaligned = 1'b0;
    case (st_size_e'(size))
      SIZE_BYTE: misaligned = 1'b0;
      SIZE_HALF: misaligned = offset[0];
      SIZE_WORD: misaligned = (offset != 2'b00);
      default:   misaligned = 1'b1;
    endcase
    be    = size_to_mask(st_size_e'(size)) << offset;
    wdata = data << {offset, 3'b000};
  end

endmodule

// File: rtl/store_buffer.sv
// Store buffer: queues encoded stores in a FIFO, drains them one at a time
// to data memory through an IDLE/WRITE handshake, and looks up pending
// stores for loads. Full-word load forwarding is built only when the macro
// STORE_BUF_FWD_EN is defined; otherwise any matching pending store makes
// the load stall via ld_conflict.
module store_buffer
  import core_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        st_valid,
  output logic        st_ready,
  input  logic [31:0] st_addr,
  input  logic [31:0] st_data,
  input  logic [1:0]  st_size,
  output logic        st_err,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] ld_addr,
  output logic        ld_hit,
  output logic [31:0] ld_data,
  output logic        ld_conflict,
  output logic        empty
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  sb_entry_t        entries [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  sb_state_e        state;
  sb_state_e        next_state;
  logic             load_head;
  logic             pop;
  logic             accept;
  logic             full;
  logic [3:0]       enc_be;
  logic [31:0]      enc_wdata;
  logic             enc_misaligned;
  logic             match_any;
  logic [3:0]       match_be;
  logic [31:0]      match_wdata;
  logic [PTR_W-1:0] scan_idx;
  logic             unused_ld_bits;

  // Byte lanes inside the word never affect the word-granular lookup.
  assign unused_ld_bits = ^ld_addr[1:0];

  sb_lane_encode u_encode (
    .offset     (st_addr[1:0]),
    .size       (st_size),
    .data       (st_data),
    .be         (enc_be),
    .wdata      (enc_wdata),
    .misaligned (enc_misaligned)
  );

  // Ready depends on occupancy only, so a pop in the same cycle does not
  // open a slot until the following cycle. The entry under write still
  // counts as occupied.
  assign full     = (count == CNT_W'(DEPTH));
  assign st_ready = ~full;
  assign accept   = st_valid & ~full & ~enc_misaligned;
  assign st_err   = reset & st_valid & enc_misaligned;
  assign empty    = (count == '0) && (state == IDLE);

  // Drain state register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  // Drain sequencing: IDLE latches the oldest entry, WRITE holds it until ack.
  always_comb begin
    next_state = state;
    load_head  = 1'b0;
    pop        = 1'b0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          load_head  = 1'b1;
          next_state = WRITE;
        end
      end
      WRITE: begin
        mem_we = 1'b1;
        if (mem_ack) begin
          pop        = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Memory request registers, held stable for the whole WRITE state.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
    end else if (load_head) begin
      mem_addr  <= {entries[rd_ptr].addr, 2'b00};
      mem_wdata <= entries[rd_ptr].wdata;
      mem_be    <= entries[rd_ptr].be;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth wraps naturally.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (pop)    rd_ptr <= rd_ptr + 1'b1;
      case ({accept, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; slots outside the occupied range are never read.
  always_ff @(posedge clock) begin
    if (accept) begin
      entries[wr_ptr] <= '{addr: st_addr[31:2], wdata: enc_wdata, be: enc_be};
    end
  end

  // Scan oldest to youngest so the youngest matching entry wins.
  always_comb begin
    match_any   = 1'b0;
    match_be    = '0;
    match_wdata = '0;
    scan_idx    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rd_ptr + PTR_W'(i);
      if ((CNT_W'(i) < count) && (entries[scan_idx].addr == ld_addr[31:2])) begin
        match_any   = 1'b1;
        match_be    = entries[scan_idx].be;
        match_wdata = entries[scan_idx].wdata;
      end
    end
  end

`ifdef STORE_BUF_FWD_EN
  // Forward only a full-word youngest match; a partial one forces a stall.
  always_comb begin
    ld_hit      = match_any && (match_be == 4'b1111);
    ld_conflict = match_any && (match_be != 4'b1111);
    ld_data     = ld_hit ? match_wdata : '0;
  end
`else
  logic unused_fwd;
  assign unused_fwd = ^{match_be, match_wdata};

  // Without forwarding, any pending store to the word stalls the load.
  always_comb begin
    ld_hit      = 1'b0;
    ld_data     = '0;
    ld_conflict = match_any;
  end
`endif

endmodule
